sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserialiser. It succeeds the fixed 4-bit shifter with:
- configurable word width and bit order;
- a bit-valid strobe and a frame-realign input;
- a double-buffered parallel output with a valid/ready handshake and overrun detection.

It sits between a serial bit source (UART/SPI-style front end) and any word-wide consumer in the same clock domain.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_shift_core.sv | 69 ++++++
 rtl/sipo_deser.sv | 85 ++++++++
 tb/tb_sipo_deser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserialiser.
// Holds the counter-width function and the output holding-register state encoding.
package sipo_pkg;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter; emits a one-cycle word_done strobe carrying the
// completed word (including the completing bit) in the same cycle that bit is accepted.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ser_in,
    input  logic                         ser_valid,
    input  logic                         frame_start,
    output logic                         word_done,
    output logic [WIDTH-1:0]             word,
    output logic [cnt_width(WIDTH)-1:0]  bit_cnt
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             done;

    always_comb begin
        shifted  = '0;
        sr_next  = sr;
        cnt_next = cnt;
        done     = 1'b0;
        if (ser_valid) begin
            // A realign starts from a cleared register so no partial bits leak into the word.
            if (frame_start) begin
                shifted  = '0;
                cnt_next = CW'(1);
            end else begin
                shifted  = sr;
                cnt_next = cnt + CW'(1);
            end
            if (MSB_FIRST) begin
                shifted = {shifted[WIDTH-2:0], ser_in};
            end else begin
                shifted = {ser_in, shifted[WIDTH-1:1]};
            end
            if (cnt_next == CW'(WIDTH)) begin
                done     = 1'b1;
                cnt_next = '0;
            end
            sr_next = shifted;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
        end
    end

    assign word      = shifted;
    assign word_done = done;
    assign bit_cnt   = cnt;

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserialiser with a registered output word,
// valid/ready handshake and a one-cycle overrun pulse when a completed word is dropped.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ser_in,
    input  logic                         ser_valid,
    input  logic                         frame_start,
    output logic [WIDTH-1:0]             par_out,
    output logic                         par_valid,
    input  logic                         par_ready,
    output logic                         overrun,
    output logic [cnt_width(WIDTH)-1:0]  bit_cnt
);

    logic             word_done;
    logic [WIDTH-1:0] word;
    out_state_e       state;
    out_state_e       state_next;
    logic             load;
    logic             overrun_next;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .word_done   (word_done),
        .word        (word),
        .bit_cnt     (bit_cnt)
    );

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        overrun_next = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (word_done) begin
                    load       = 1'b1;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                // Consume and refill in the same cycle keeps the word stream bubble-free.
                if (par_ready) begin
                    if (word_done) begin
                        load = 1'b1;
                    end else begin
                        state_next = OUT_EMPTY;
                    end
                end else if (word_done) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= OUT_EMPTY;
            par_out <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= overrun_next;
            if (load) begin
                par_out <= word;
            end
        end
    end

    assign par_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: a 4-bit LSB-first instance and an 8-bit MSB-first
// instance share clock and reset; expected values are hand-derived constants.
module tb_sipo_deser;

    logic clk;
    logic reset;

    logic       ser_in4, ser_valid4, frame_start4, par_ready4;
    logic [3:0] par_out4;
    logic       par_valid4, overrun4;
    logic [2:0] bit_cnt4;

    logic       ser_in8, ser_valid8, frame_start8, par_ready8;
    logic [7:0] par_out8;
    logic       par_valid8, overrun8;
    logic [3:0] bit_cnt8;

    int n_total = 0;
    int n_bad   = 0;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .ser_in      (ser_in4),
        .ser_valid   (ser_valid4),
        .frame_start (frame_start4),
        .par_out     (par_out4),
        .par_valid   (par_valid4),
        .par_ready   (par_ready4),
        .overrun     (overrun4),
        .bit_cnt     (bit_cnt4)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .ser_in      (ser_in8),
        .ser_valid   (ser_valid8),
        .frame_start (frame_start8),
        .par_out     (par_out8),
        .par_valid   (par_valid8),
        .par_ready   (par_ready8),
        .overrun     (overrun8),
        .bit_cnt     (bit_cnt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit4(input logic b);
        ser_in4    = b;
        ser_valid4 = 1'b1;
        step();
        ser_valid4 = 1'b0;
        ser_in4    = ~b;
    endtask

    task automatic bit8(input logic b, input logic fs);
        ser_in8      = b;
        ser_valid8   = 1'b1;
        frame_start8 = fs;
        step();
        ser_valid8   = 1'b0;
        frame_start8 = 1'b0;
        ser_in8      = ~b;
    endtask

    task automatic word4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) bit4(w[i]);
    endtask

    task automatic word8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit8(w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] tail;
        reset = 1'b1;
        ser_in4 = 1'b0; ser_valid4 = 1'b0; frame_start4 = 1'b0; par_ready4 = 1'b0;
        ser_in8 = 1'b0; ser_valid8 = 1'b0; frame_start8 = 1'b0; par_ready8 = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_par_out", 64'(par_out4), 64'h0);
        check("rst_valid", 64'(par_valid4), 64'h0);
        check("rst_cnt", 64'(bit_cnt4), 64'h0);
        check("rst_ovr", 64'(overrun4), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Legacy order: 1,0,1,1 -> 4'b1101
        bit4(1'b1);
        bit4(1'b0);
        check("leg_cnt2", 64'(bit_cnt4), 64'd2);
        bit4(1'b1);
        check("leg_valid3", 64'(par_valid4), 64'h0);
        bit4(1'b1);
        check("leg_par_out", 64'(par_out4), 64'hD);
        check("leg_valid", 64'(par_valid4), 64'h1);
        check("leg_cnt", 64'(bit_cnt4), 64'h0);
        check("leg_ovr", 64'(overrun4), 64'h0);
        par_ready4 = 1'b1;
        step();
        check("leg_consume", 64'(par_valid4), 64'h0);

        // Ready tied high: 0x3 then 0xC
        word4(4'h3);
        check("rdy_w0", 64'(par_out4), 64'h3);
        check("rdy_v0", 64'(par_valid4), 64'h1);
        bit4(1'b0);
        check("rdy_drain", 64'(par_valid4), 64'h0);
        bit4(1'b0);
        bit4(1'b1);
        bit4(1'b1);
        check("rdy_w1", 64'(par_out4), 64'hC);
        check("rdy_v1", 64'(par_valid4), 64'h1);
        check("rdy_ovr", 64'(overrun4), 64'h0);
        step();

        // Consume and refill on the same edge: valid never drops
        par_ready4 = 1'b0;
        word4(4'h3);
        bit4(1'b0);
        bit4(1'b0);
        bit4(1'b1);
        check("b2b_hold", 64'(par_out4), 64'h3);
        par_ready4 = 1'b1;
        bit4(1'b1);
        check("b2b_par_out", 64'(par_out4), 64'hC);
        check("b2b_valid", 64'(par_valid4), 64'h1);
        check("b2b_ovr", 64'(overrun4), 64'h0);
        step();
        check("b2b_drain", 64'(par_valid4), 64'h0);

        // Overrun: 0x9 held, 0x6 dropped
        par_ready4 = 1'b0;
        word4(4'h9);
        check("ovr_first", 64'(par_out4), 64'h9);
        check("ovr_none_yet", 64'(overrun4), 64'h0);
        word4(4'h6);
        check("ovr_pulse", 64'(overrun4), 64'h1);
        check("ovr_par_out", 64'(par_out4), 64'h9);
        check("ovr_valid", 64'(par_valid4), 64'h1);
        step();
        check("ovr_one_cycle", 64'(overrun4), 64'h0);
        par_ready4 = 1'b1;
        step();
        par_ready4 = 1'b0;
        check("ovr_consume", 64'(par_valid4), 64'h0);

        // MSB-first 0xA5 with a gap cycle after every valid bit
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            bit8(a5[i], 1'b0);
            if (i == 1) check("msb_cnt7", 64'(bit_cnt8), 64'd7);
            if (i == 0) begin
                check("msb_par_out", 64'(par_out8), 64'hA5);
                check("msb_valid", 64'(par_valid8), 64'h1);
                check("msb_cnt0", 64'(bit_cnt8), 64'h0);
            end
            step();
            if (i == 1) check("msb_valid_early", 64'(par_valid8), 64'h0);
        end
        par_ready8 = 1'b1;
        step();
        par_ready8 = 1'b0;
        check("msb_consume", 64'(par_valid8), 64'h0);

        // frame_start without ser_valid is ignored
        bit8(1'b1, 1'b0);
        bit8(1'b1, 1'b0);
        frame_start8 = 1'b1;
        step();
        frame_start8 = 1'b0;
        check("fs_ignored", 64'(bit_cnt8), 64'd2);

        // Realign: third partial bit, then frame_start with first bit of 0x5A
        bit8(1'b1, 1'b0);
        bit8(1'b0, 1'b1);
        check("realign_cnt", 64'(bit_cnt8), 64'd1);
        tail = 8'h5A;
        for (int i = 6; i >= 0; i--) bit8(tail[i], 1'b0);
        check("realign_par_out", 64'(par_out8), 64'h5A);
        check("realign_valid", 64'(par_valid8), 64'h1);
        par_ready8 = 1'b1;
        step();
        par_ready8 = 1'b0;

        // Asynchronous reset with bit_cnt=5 and a pending word
        word8(8'hFF);
        for (int i = 0; i < 5; i++) bit8(1'b1, 1'b0);
        check("mid_cnt5", 64'(bit_cnt8), 64'd5);
        check("mid_valid1", 64'(par_valid8), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_par_out", 64'(par_out8), 64'h0);
        check("mid_valid", 64'(par_valid8), 64'h0);
        check("mid_cnt", 64'(bit_cnt8), 64'h0);
        check("mid_ovr", 64'(overrun8), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        word8(8'h3C);
        check("post_rst_word", 64'(par_out8), 64'h3C);
        check("post_rst_valid", 64'(par_valid8), 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        n_bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

endmodule
